// File: rtl/sparse_mult_by_e_ctrl.sv
// rtl/sparse_mult_by_e_ctrl.sv - sparse multiply-by-E sequencer with GF(2) row accumulation and word packing.
// Optional macro SPARSE_MULT_BY_E_OVERRUN_ERR_EN adds o_error for entry-list overrun.
module sparse_mult_by_e_ctrl #(
  parameter int WIDTH       = 8,
  parameter int NUM_ENTRIES = 1024,
  parameter int COL_W       = 10,
  parameter int ROW_W       = 10
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic [ROW_W-1:0]               i_num_rows,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_entry_rd,
  output logic [$clog2(NUM_ENTRIES)-1:0] o_entry_addr,
  input  logic [COL_W-1:0]               i_entry_col,
  input  logic                           i_entry_last,
  output logic                           o_vec_rd,
  output logic [COL_W-1:0]               o_vec_addr,
  input  logic                           i_vec_bit,
`ifdef SPARSE_MULT_BY_E_OVERRUN_ERR_EN
  output logic                           o_error,
`endif
  output logic [WIDTH-1:0]               o_out_data,
  output logic                           o_out_valid,
  input  logic                           i_out_ready
);

  localparam int AW = $clog2(NUM_ENTRIES);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE, ENTRY_RD, ENTRY_WAIT, VEC_RD, VEC_WAIT, OUT, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [AW-1:0]     entry_addr_q, entry_addr_d;
  logic [COL_W-1:0]  vec_addr_q, vec_addr_d;
  logic [ROW_W-1:0]  num_rows_q, num_rows_d;
  logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
  logic [BW-1:0]     bit_idx_q, bit_idx_d;
  logic              acc_q, acc_d;
  logic              last_q, last_d;
  logic [WIDTH-1:0]  pack_q, pack_d;
  logic              done_q;
`ifdef SPARSE_MULT_BY_E_OVERRUN_ERR_EN
  logic              err_q, err_d;
`endif

  logic              sentinel;
  logic [ROW_W-1:0]  row_next;
  logic              word_full;
  logic              finish;
  logic              finish_bit;

  assign sentinel  = &i_entry_col;
  assign row_next  = row_cnt_q + ROW_W'(1);
  assign word_full = (bit_idx_q == BW'(WIDTH-1));

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    entry_addr_d = entry_addr_q;
    vec_addr_d   = vec_addr_q;
    num_rows_d   = num_rows_q;
    row_cnt_d    = row_cnt_q;
    bit_idx_d    = bit_idx_q;
    acc_d        = acc_q;
    last_d       = last_q;
    pack_d       = pack_q;
    finish       = 1'b0;
    finish_bit   = 1'b0;
`ifdef SPARSE_MULT_BY_E_OVERRUN_ERR_EN
    err_d        = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (i_start) begin
          num_rows_d = i_num_rows;
          ptr_d      = '0;
          row_cnt_d  = '0;
          bit_idx_d  = '0;
          acc_d      = 1'b0;
          pack_d     = '0;
`ifdef SPARSE_MULT_BY_E_OVERRUN_ERR_EN
          err_d      = 1'b0;
`endif
          state_d    = (i_num_rows == '0) ? DONE : ENTRY_RD;
        end
      end
      ENTRY_RD: state_d = ENTRY_WAIT;
      ENTRY_WAIT: begin
        last_d = i_entry_last;
        ptr_d  = ptr_q + AW'(1);
        if (sentinel) begin
          finish = 1'b1;
        end else begin
          vec_addr_d = i_entry_col;
          state_d    = VEC_RD;
        end
`ifdef SPARSE_MULT_BY_E_OVERRUN_ERR_EN
        // Wrapping is only legal when this entry closes the final row.
        if (ptr_q == AW'(NUM_ENTRIES-1) &&
            !((sentinel || i_entry_last) && row_next == num_rows_q)) begin
          err_d   = 1'b1;
          finish  = 1'b0;
          state_d = DONE;
        end
`endif
      end
      VEC_RD: state_d = VEC_WAIT;
      VEC_WAIT: begin
        if (last_q) begin
          finish     = 1'b1;
          finish_bit = acc_q ^ i_vec_bit;
        end else begin
          acc_d   = acc_q ^ i_vec_bit;
          state_d = ENTRY_RD;
        end
      end
      OUT: begin
        if (i_out_ready) begin
          pack_d  = '0;
          state_d = (row_cnt_q == num_rows_q) ? DONE : ENTRY_RD;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (finish) begin
      pack_d[bit_idx_q] = finish_bit;
      acc_d             = 1'b0;
      row_cnt_d         = row_next;
      bit_idx_d         = word_full ? '0 : bit_idx_q + BW'(1);
      state_d           = (word_full || row_next == num_rows_q) ? OUT : ENTRY_RD;
    end

    // Entry address is registered so it holds between strobes.
    if (state_d == ENTRY_RD) entry_addr_d = ptr_d;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      entry_addr_q <= '0;
      vec_addr_q   <= '0;
      num_rows_q   <= '0;
      row_cnt_q    <= '0;
      bit_idx_q    <= '0;
      acc_q        <= 1'b0;
      last_q       <= 1'b0;
      pack_q       <= '0;
      done_q       <= 1'b0;
`ifdef SPARSE_MULT_BY_E_OVERRUN_ERR_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      entry_addr_q <= entry_addr_d;
      vec_addr_q   <= vec_addr_d;
      num_rows_q   <= num_rows_d;
      row_cnt_q    <= row_cnt_d;
      bit_idx_q    <= bit_idx_d;
      acc_q        <= acc_d;
      last_q       <= last_d;
      pack_q       <= pack_d;
      done_q       <= (state_q == DONE);
`ifdef SPARSE_MULT_BY_E_OVERRUN_ERR_EN
      err_q        <= err_d;
`endif
    end
  end

  assign o_busy       = (state_q != IDLE);
  assign o_done       = done_q;
  assign o_entry_rd   = (state_q == ENTRY_RD);
  assign o_entry_addr = entry_addr_q;
  assign o_vec_rd     = (state_q == VEC_RD);
  assign o_vec_addr   = vec_addr_q;
  assign o_out_valid  = (state_q == OUT);
  assign o_out_data   = pack_q;
`ifdef SPARSE_MULT_BY_E_OVERRUN_ERR_EN
  assign o_error      = err_q;
`endif

endmodule
